// File: rtl/mc_mem_responder.sv
// Memory-side responder for the multicycle MIPS core: unified word RAM with
// configurable wait states, a one-cycle MemReady pulse and request rejection.
module mc_mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr,
    output logic        Busy
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned HI_SHIFT = ADDR_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_ERR
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               latch_c;

    logic               op_wr_q;
    logic [ADDR_W-1:0]  idx_q;
    logic [31:0]        wdata_q;

    logic [31:0]        mem [DEPTH];

    logic               req_c;
    logic               reject_c;
    logic               commit_c;
    logic               op_wr_c;
    logic [ADDR_W-1:0]  idx_c;
    logic [31:0]        wdata_c;

    // Request decode: conflicting strobes, misalignment and out-of-range are rejected.
    assign req_c    = MemRead | MemWrite;
    assign reject_c = (MemRead & MemWrite)
                    | (Addr[1:0] != 2'b00)
                    | ((Addr >> HI_SHIFT) != 32'd0);

    // With zero wait states the commit happens on the accepting edge, so take operands live.
    assign op_wr_c  = (state == ST_IDLE) ? MemWrite : op_wr_q;
    assign idx_c    = (state == ST_IDLE) ? Addr[ADDR_W+1:2] : idx_q;
    assign wdata_c  = (state == ST_IDLE) ? WriteData : wdata_q;
    assign commit_c = (state_nxt == ST_RESP);

    // State register and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_c) begin
                    if (reject_c) begin
                        state_nxt = ST_ERR;
                    end else begin
                        latch_c = 1'b1;
                        if (WAIT_CYCLES != 0) begin
                            state_nxt = ST_WAIT;
                            cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
                        end else begin
                            state_nxt = ST_RESP;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Latched request operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (latch_c) begin
            op_wr_q <= MemWrite;
            idx_q   <= Addr[ADDR_W+1:2];
            wdata_q <= WriteData;
        end
    end

    // RAM array is not reset; a write in flight during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && commit_c && op_wr_c) begin
            mem[idx_c] <= wdata_c;
        end
    end

    // Registered outputs, computed from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReadData <= '0;
            MemReady <= 1'b0;
            MemErr   <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            if (commit_c && !op_wr_c) begin
                ReadData <= mem[idx_c];
            end
            MemReady <= (state_nxt == ST_RESP);
            MemErr   <= (state_nxt == ST_ERR);
            Busy     <= (state_nxt == ST_WAIT) || (state_nxt == ST_RESP);
        end
    end

endmodule

// File: tb/tb_mc_mem_responder.sv
// Scoreboard bench for mc_mem_responder: two instances (2 and 0 wait states)
// checked against a word-array reference model of the memory.
module tb_mc_mem_responder;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned NWORDS = 64;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];

    logic [31:0] rdata_a, rdata_b;
    logic        rdy_a, rdy_b, err_a, err_b, busy_a, busy_b;
    logic [31:0] rdata_v [2];
    logic        rdy_v   [2];
    logic        err_v   [2];
    logic        busy_v  [2];

    assign rdata_v[0] = rdata_a;
    assign rdata_v[1] = rdata_b;
    assign rdy_v[0]   = rdy_a;
    assign rdy_v[1]   = rdy_b;
    assign err_v[0]   = err_a;
    assign err_v[1]   = err_b;
    assign busy_v[0]  = busy_a;
    assign busy_v[1]  = busy_b;

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          brun [2] = '{0, 0};
    logic [31:0] mem_m [2][256];
    logic [31:0] last_rd [2];
    exp_t        sb [2][$];

    mc_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .MemRead(rd[0]), .MemWrite(wr[0]),
        .Addr(addr[0]), .WriteData(wdata[0]), .ReadData(rdata_a),
        .MemReady(rdy_a), .MemErr(err_a), .Busy(busy_a)
    );

    mc_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .MemRead(rd[1]), .MemWrite(wr[1]),
        .Addr(addr[1]), .WriteData(wdata[1]), .ReadData(rdata_b),
        .MemReady(rdy_b), .MemErr(err_b), .Busy(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wc(int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h at cycle %0d",
                     nm, i, act, exp, cyc);
        end
    endtask

    // Reference model: accepted reads return the current word, writes update it.
    task automatic expect_req(int i, bit r, bit w, logic [31:0] a, logic [31:0] d, int rcyc);
        exp_t              e;
        logic [ADDR_W-1:0] idx;
        idx      = a[ADDR_W+1:2];
        e.is_err = (r && w) || (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
        e.cyc    = e.is_err ? rcyc : rcyc + wc(i);
        if (!e.is_err) begin
            if (r) last_rd[i] = mem_m[i][idx];
            else   mem_m[i][idx] = d;
        end
        e.data = last_rd[i];
        sb[i].push_back(e);
    endtask

    task automatic check_evt(int i);
        exp_t e;
        chk("ready_err_exclusive", i, 32'(rdy_v[i] & err_v[i]), 32'd0);
        if (sb[i].size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_response dut%0d: ready=%0b err=%0b expected no response",
                     i, rdy_v[i], err_v[i]);
        end else begin
            e = sb[i].pop_front();
            chk("ready_pulse", i, 32'(rdy_v[i]), 32'(!e.is_err));
            chk("err_pulse", i, 32'(err_v[i]), 32'(e.is_err));
            chk("latency", i, 32'(cyc), 32'(e.cyc));
            chk("read_data", i, rdata_v[i], e.data);
            if (e.is_err) chk("busy_on_err", i, 32'(busy_v[i]), 32'd0);
            else          chk("busy_run", i, 32'(brun[i]), 32'(wc(i) + 1));
        end
    endtask

    // Monitor: sampled mid-cycle, pops the scoreboard on every response pulse.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                brun[i] = 0;
            end else begin
                if (busy_v[i]) brun[i]++;
                else           brun[i] = 0;
                if (busy_v[i]) chk("busy_len", i, 32'(brun[i] <= wc(i) + 1), 32'd1);
                if (rdy_v[i] || err_v[i]) check_evt(i);
            end
        end
    end

    task automatic drain(int i);
        int n = 0;
        while (sb[i].size() != 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (sb[i].size() != 0) begin
            checks++;
            fails++;
            $display("FAIL response_timeout dut%0d: %0d outstanding expected 0", i, sb[i].size());
            sb[i].delete();
        end
    endtask

    task automatic issue(int i, bit r, bit w, logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        rd[i] = r; wr[i] = w; addr[i] = a; wdata[i] = d;
        expect_req(i, r, w, a, d, cyc + 1);
        @(negedge clk);
        rd[i] = 1'b0; wr[i] = 1'b0;
        drain(i);
    endtask

    // Strobe held across several accesses: one new request per turnaround.
    task automatic back_to_back(int i, logic [31:0] a, int k);
        int r0;
        @(negedge clk);
        rd[i] = 1'b1; wr[i] = 1'b0; addr[i] = a;
        r0 = cyc + 1;
        for (int j = 0; j < k; j++) expect_req(i, 1'b1, 1'b0, a, 32'd0, r0 + j * (wc(i) + 2));
        repeat ((wc(i) + 2) * (k - 1) + 1) @(negedge clk);
        rd[i] = 1'b0;
        drain(i);
    endtask

    task automatic reset_checks();
        for (int i = 0; i < 2; i++) begin
            chk("rst_readdata", i, rdata_v[i], 32'd0);
            chk("rst_ready", i, 32'(rdy_v[i]), 32'd0);
            chk("rst_err", i, 32'(err_v[i]), 32'd0);
            chk("rst_busy", i, 32'(busy_v[i]), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          r, w;
        logic [31:0] a;
        int          i, p;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0; last_rd[k] = '0;
            for (int m = 0; m < 256; m++) mem_m[k][m] = '0;
        end
        repeat (3) begin
            @(negedge clk);
            #1 reset_checks();
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < int'(NWORDS); n++) begin
            issue(0, 1'b0, 1'b1, 32'(n * 4), 32'd0);
            issue(1, 1'b0, 1'b1, 32'(n * 4), 32'd0);
        end

        issue(0, 1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D);
        issue(0, 1'b1, 1'b0, 32'h0000_0040, 32'd0);
        repeat (3) @(negedge clk);
        chk("read_hold", 0, rdata_a, 32'hCAFE_F00D);

        issue(1, 1'b0, 1'b1, 32'h0000_0004, 32'h1111_2222);
        issue(1, 1'b1, 1'b0, 32'h0000_0004, 32'd0);

        issue(0, 1'b1, 1'b0, 32'h0000_0042, 32'd0);
        issue(0, 1'b1, 1'b1, 32'h0000_0020, 32'h5555_5555);
        issue(0, 1'b1, 1'b0, 32'h0000_0400, 32'd0);
        chk("err_keeps_readdata", 0, rdata_a, 32'hCAFE_F00D);

        // Mid-WAIT reset drops the pending write of 0xDEADBEEF.
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        wr[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (3) begin
            #1 reset_checks();
            @(negedge clk);
        end
        rst_n = 1'b1;
        issue(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0);

        // Strobe activity while the responder is busy must be ignored.
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 32'h14; wdata[0] = 32'h0BAD_F00D;
        expect_req(0, 1'b0, 1'b1, 32'h14, 32'h0BAD_F00D, cyc + 1);
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 32'h80; wdata[0] = 32'hFFFF_0000;
        @(negedge clk);
        wr[0] = 1'b0; rd[0] = 1'b1;
        @(negedge clk);
        rd[0] = 1'b0;
        drain(0);
        issue(0, 1'b1, 1'b0, 32'h0000_0080, 32'd0);
        issue(0, 1'b1, 1'b0, 32'h0000_0014, 32'd0);

        issue(0, 1'b0, 1'b1, 32'h0000_0008, 32'h1357_2468);
        back_to_back(0, 32'h0000_0008, 4);
        issue(1, 1'b0, 1'b1, 32'h0000_0008, 32'h2468_1357);
        back_to_back(1, 32'h0000_0008, 4);

        for (int n = 0; n < 80; n++) begin
            i = int'($urandom_range(0, 1));
            p = int'($urandom_range(0, 19));
            if (p == 0) begin
                r = 1'b1; w = 1'b1;
            end else begin
                r = 1'($urandom_range(0, 1)); w = !r;
            end
            p = int'($urandom_range(0, 9));
            if (p == 0)      a = 32'($urandom_range(0, NWORDS - 1) * 4 + $urandom_range(1, 3));
            else if (p == 1) a = 32'h400 << $urandom_range(0, 21);
            else             a = 32'($urandom_range(0, NWORDS - 1) * 4);
            issue(i, r, w, a, $urandom);
        end

        repeat (4) @(negedge clk);
        chk("final_hold", 0, rdata_a, last_rd[0]);
        chk("final_hold", 1, rdata_b, last_rd[1]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/mc_mem_responder.md
Name: mc_mem_responder

Overview:
- Memory-side responder for the multicycle MIPS control/datapath.
- Serves word reads and writes requested by the control FSM's MemRead/MemWrite strobes, using the datapath's IorD-muxed address.
- Models a unified instruction/data RAM with a configurable number of wait states. Returns data with a one-cycle MemReady pulse so the control FSM can stall until the memory responds.

Parameters:
- ADDR_W, 8, word-address width; RAM depth is 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2, extra wait-state cycles inserted before the response (0..15).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- MemRead  input  1  read request strobe from control
- MemWrite  input  1  write request strobe from control
- Addr  input  32  byte address (PC or ALUOut, chosen by IorD)
- WriteData  input  32  store data (register B)
- ReadData  output  32  read data, held until the next read completes
- MemReady  output  1  one-cycle pulse when an access completes
- MemErr  output  1  one-cycle pulse when a request is rejected
- Busy  output  1  high while in WAIT or RESP

Behaviour:
- Reset is asynchronous and active-low.
  - While rst_n=0: state=IDLE, ReadData=0, MemReady=0, MemErr=0, Busy=0, wait counter=0.
  - RAM contents are not reset. Simulation initialises them to 0.
- States: IDLE, WAIT, RESP, ERR.
- IDLE, at a rising edge:
  - Neither strobe high: stay in IDLE.
  - A request is rejected (next state = ERR, no RAM access) if any of the following holds:
    - MemRead=1 and MemWrite=1 together;
    - Addr[1:0] != 0 (misaligned);
    - Addr[31:ADDR_W+2] != 0 (out of range).
  - Otherwise, latch the operation, word index Addr[ADDR_W+1:2] and WriteData:
    - WAIT_CYCLES > 0: go to WAIT with counter = WAIT_CYCLES-1.
    - WAIT_CYCLES = 0: go directly to RESP.
- WAIT:
  - counter != 0: decrement and stay in WAIT.
  - counter = 0: go to RESP.
  - Strobes and Addr are ignored in this state.
- Commit on the edge entering RESP:
  - Write: RAM[index] <= latched WriteData.
  - Read: ReadData <= RAM[index].
- RESP:
  - MemReady=1 for exactly this cycle.
  - Next state is always IDLE; strobes are ignored.
- ERR:
  - MemErr=1 for exactly this cycle. ReadData and RAM are unchanged.
  - Next state is always IDLE.
- Latency: request sampled at edge N gives MemReady high during cycle N+WAIT_CYCLES+1.
- Throughput: minimum gap from one accepted request to the next is WAIT_CYCLES+2 edges.
  - A strobe still high in IDLE after RESP is treated as a new request. The control FSM must drop the strobe before then.
- Busy=1 in WAIT and RESP, 0 in IDLE and ERR. MemReady and MemErr are never high together.
- Read-after-write to the same word returns the new data. Writes commit before any later read is sampled.
- Reset mid-operation: the latched request is discarded, a pending write is not committed, and ReadData returns to 0.
- All outputs are registered; there is no combinational path from any input to any output.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-WAIT of a write of 0xDEADBEEF to 0x10 -> all outputs 0, and a later read of 0x10 returns its prior value 0x00000000.
- Write then read, WAIT_CYCLES=2:
  - Write 0xCAFEF00D to Addr 0x0000_0040 -> MemReady pulses exactly 3 cycles after the request edge.
  - Read 0x40 -> ReadData=0xCAFEF00D with MemReady, and it is held afterwards.
- Zero wait states, WAIT_CYCLES=0: read of Addr 0x4 -> MemReady on the cycle immediately after the request edge; Busy high for exactly 1 cycle.
- Errors:
  - Addr 0x42 read -> MemErr pulse 1 cycle later, no MemReady, ReadData unchanged.
  - MemRead=MemWrite=1 -> MemErr.
  - Addr 0x0000_0400 with ADDR_W=8 -> MemErr.
- Busy masking: during WAIT, toggle MemWrite with Addr 0x80 -> ignored; RAM[0x80>>2] unchanged; only the original request completes.
- Back-to-back: hold MemRead high continuously on Addr 0x8 -> MemReady pulses every WAIT_CYCLES+2 cycles (4 for the default).
